// File: rtl/apb_uart_pkg.sv
// Shared FSM encoding, register map and helpers for the APB-UART requester.
package apb_uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam logic [7:0] ADDR_TXPUSH_RXPOP = 8'h00;
    localparam logic [7:0] ADDR_TXDATA       = 8'h04;
    localparam logic [7:0] ADDR_STAT_A       = 8'h08;
    localparam logic [7:0] ADDR_RXDATA       = 8'h0C;

    localparam logic [7:0] DEFAULT_MAX_ADDR       = ADDR_RXDATA;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 16;

    // Word-aligned and inside the register map.
    function automatic logic addr_legal(input logic [7:0] addr, input logic [7:0] max_addr);
        return (addr[1:0] == 2'b00) && (addr <= max_addr);
    endfunction

endpackage

// File: rtl/apb_uart_if.sv
// Command/response stream plus APB requester signals of the APB-UART master.
interface apb_uart_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter; expired fires on the LIMIT-th consecutive tick.
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    assign expired = tick && (count == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/apb_uart_master.sv
// APB requester bridging a cmd/rsp stream to the APB-UART slave port.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_uart_master
    import apb_uart_pkg::*;
#(
    parameter logic [7:0] MAX_ADDR = DEFAULT_MAX_ADDR
`ifdef APB_MASTER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input logic        PCLK,
    input logic        PRESET,
    apb_uart_if.master bus
);

    apb_state_t state;
    logic       accept;
    logic       timeout;

    // Derived from the state register only, so no combinational path from cmd_valid.
    assign bus.cmd_ready = (state == IDLE);
    assign accept        = bus.cmd_valid && (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (accept),
        .tick    ((state == ACCESS) && !bus.PREADY),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every state/output register uses <= so all updates see pre-edge values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state         <= IDLE;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= 8'h00;
            bus.PWDATA    <= 8'h00;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 8'h00;
            bus.rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (addr_legal(bus.cmd_addr, MAX_ADDR)) begin
                            state      <= SETUP;
                            bus.PSEL   <= 1'b1;
                            bus.PWRITE <= bus.cmd_write;
                            bus.PADDR  <= bus.cmd_addr;
                            bus.PWDATA <= bus.cmd_wdata;
                        end else begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= 8'h00;
                        end
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.PENABLE <= 1'b1;
                end
                ACCESS: begin
                    // A ready slave on the limit cycle still completes normally.
                    if (bus.PREADY) begin
                        state         <= RESP;
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= bus.PWRITE ? 8'h00 : bus.PRDATA;
                    end else if (timeout) begin
                        state         <= RESP;
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= 8'h00;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= 8'h00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_master.sv
// Self-checking bench for apb_uart_master: timeline model plus directed commands.
module tb_apb_uart_master;
    import apb_uart_pkg::*;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_uart_if bus ();

    apb_uart_master dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // APB slave: PREADY low for cur_wait ACCESS cycles, then high.
    int         cur_wait  = 0;
    logic [7:0] cur_rdata = 8'h00;
    int         acc_cnt   = 0;

    always @(negedge clk) begin
        if (bus.PSEL && bus.PENABLE) begin
            bus.PREADY = (acc_cnt >= cur_wait);
            acc_cnt++;
        end else begin
            bus.PREADY = 1'b0;
            acc_cnt    = 0;
        end
        bus.PRDATA = cur_rdata;
    end

    // Transaction plan: cycle offsets (edges after accept) of each phase.
    typedef struct {
        bit         err;
        int         apb_end;
        int         rsp_t;
        logic [7:0] rdata;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } plan_t;

    function automatic plan_t make_plan(bit wr, logic [7:0] addr, logic [7:0] wdata,
                                        int waits, logic [7:0] rdata);
        plan_t p;
        p.wr    = wr;
        p.addr  = addr;
        p.wdata = wdata;
        if ((int'(addr) % 4) != 0 || int'(addr) > 12) begin
            p.err = 1'b1; p.apb_end = 0; p.rsp_t = 1; p.rdata = 8'h00;
        end else if (TO_EN && waits >= 16) begin
            p.err = 1'b1; p.apb_end = 17; p.rsp_t = 18; p.rdata = 8'h00;
        end else begin
            p.err = 1'b0; p.apb_end = 2 + waits; p.rsp_t = 3 + waits;
            p.rdata = wr ? 8'h00 : rdata;
        end
        return p;
    endfunction

    bit    m_busy = 1'b0;
    int    m_t    = 0;
    plan_t m_plan;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_t    <= 0;
        end else if (!m_busy) begin
            if (bus.cmd_valid) begin
                m_busy <= 1'b1;
                m_t    <= 1;
                m_plan <= make_plan(bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, cur_wait, cur_rdata);
            end
        end else if (m_t >= m_plan.rsp_t) begin
            if (bus.rsp_ready) begin
                m_busy <= 1'b0;
                m_t    <= 0;
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        bit e_psel, e_pen, e_rv;
        e_psel = m_busy && (m_t >= 1) && (m_t <= m_plan.apb_end);
        e_pen  = m_busy && (m_t >= 2) && (m_t <= m_plan.apb_end);
        e_rv   = m_busy && (m_t >= m_plan.rsp_t);
        check("m_cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
        check("m_psel",      32'(bus.PSEL),      32'(e_psel));
        check("m_penable",   32'(bus.PENABLE),   32'(e_pen));
        check("m_rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        if (e_psel) begin
            check("m_paddr",  32'(bus.PADDR),  32'(m_plan.addr));
            check("m_pwrite", 32'(bus.PWRITE), 32'(m_plan.wr));
            check("m_pwdata", 32'(bus.PWDATA), 32'(m_plan.wdata));
        end
        if (e_rv) begin
            check("m_rsp_rdata", 32'(bus.rsp_rdata), 32'(m_plan.rdata));
            check("m_rsp_err",   32'(bus.rsp_err),   32'(m_plan.err));
        end
        if (rst) begin
            check("m_rst_paddr",  32'(bus.PADDR),     32'd0);
            check("m_rst_pwdata", 32'(bus.PWDATA),    32'd0);
            check("m_rst_pwrite", 32'(bus.PWRITE),    32'd0);
            check("m_rst_rdata",  32'(bus.rsp_rdata), 32'd0);
            check("m_rst_err",    32'(bus.rsp_err),   32'd0);
        end
    end

    task automatic run_cmd(input string tag, input bit wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input int waits, input logic [7:0] rdata,
                           input int hold, input bit drop_in, input int exp_lat,
                           input int exp_pen, input bit exp_err, input logic [7:0] exp_rdata);
        int lat, pen, psel;
        @(negedge clk);
        cur_wait      = waits;
        cur_rdata     = rdata;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.rsp_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat  = 1;
        pen  = 0;
        psel = 0;
        while (!bus.rsp_valid && lat < 100) begin
            if (bus.PSEL) psel++;
            if (bus.PENABLE) pen++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_penable_cycles"}, pen, exp_pen);
        check({tag, "_psel_cycles"}, psel, (exp_pen == 0) ? 0 : exp_pen + 1);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
        for (int i = 0; i < hold; i++) begin
            if (drop_in) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = 1'b1;
                bus.cmd_addr  = 8'h00;
                bus.cmd_wdata = 8'hEE;
            end
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
            check({tag, "_hold_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
            check({tag, "_hold_psel"}, 32'(bus.PSEL), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_done_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_psel",      32'(bus.PSEL),      32'd0);
        check("reset_penable",   32'(bus.PENABLE),   32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        rst = 1'b0;

        //       tag            wr addr   wdata  wait rdata  hold drop lat pen err rdata
        run_cmd("t1_write",     1, 8'h04, 8'h41, 0,  8'hC3, 0,   0,   3,  1,  0, 8'h00);
        run_cmd("t2_read_max",  0, 8'h0C, 8'h00, 0,  8'h5A, 0,   0,   3,  1,  0, 8'h5A);
        run_cmd("t3_wait3",     0, 8'h08, 8'h00, 3,  8'h3C, 0,   0,   6,  4,  0, 8'h3C);
        run_cmd("t4_misalign",  1, 8'h05, 8'h12, 0,  8'h00, 0,   0,   1,  0,  1, 8'h00);
        run_cmd("t4_too_high",  0, 8'h10, 8'h00, 0,  8'h77, 0,   0,   1,  0,  1, 8'h00);
        run_cmd("t5_backpress", 0, 8'h00, 8'h00, 0,  8'hA5, 5,   1,   3,  1,  0, 8'hA5);
        run_cmd("limit_ready",  0, 8'h04, 8'h00, 15, 8'h77, 0,   0,   18, 16, 0, 8'h77);
        run_cmd("write_wait2",  1, 8'h0C, 8'hFF, 2,  8'h66, 1,   0,   5,  3,  0, 8'h00);
`ifdef APB_MASTER_TIMEOUT_EN
        run_cmd("t6_timeout",   0, 8'h08, 8'h00, 20, 8'h99, 0,   0,   18, 16, 1, 8'h00);
`else
        run_cmd("t6_long_wait", 0, 8'h08, 8'h00, 20, 8'h99, 0,   0,   23, 21, 0, 8'h99);
`endif

        // Reset while the slave stalls in ACCESS: immediate abort, no response.
        @(negedge clk);
        cur_wait      = 1000;
        cur_rdata     = 8'h11;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h08;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_access", 32'(bus.PENABLE), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_psel",      32'(bus.PSEL),      32'd0);
        check("abort_penable",   32'(bus.PENABLE),   32'd0);
        check("abort_pwrite",    32'(bus.PWRITE),    32'd0);
        check("abort_paddr",     32'(bus.PADDR),     32'd0);
        check("abort_pwdata",    32'(bus.PWDATA),    32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("abort_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run_cmd("post_reset",   0, 8'h04, 8'h00, 0,  8'h3D, 0,   0,   3,  1,  0, 8'h3D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
